// File: rtl/toggle_debouncer.sv
// Multi-channel switch debouncer: per-bit 2-flop synchroniser, shared tick prescaler,
// and a per-bit stability counter that commits a new level after STABLE_TICKS ticks.
module toggle_debouncer #(
  parameter int WIDTH        = 18,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] change_pulse,
  output logic             any_change
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]    CNT_MAX   = 4'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [3:0]       cnt_q [WIDTH];
  logic [3:0]       cnt_d [WIDTH];
  logic [WIDTH-1:0] commit;
  logic [WIDTH-1:0] db_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Free-running prescaler; input activity never restarts it.
  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Any agreement clears the count, so a bounce back restarts qualification.
  always_comb begin
    commit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2[i] == db_out[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] >= CNT_MAX) begin
          commit[i] = 1'b1;
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign db_next = (db_out & ~commit) | (sync2 & commit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      db_out       <= '0;
      change_pulse <= '0;
      any_change   <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      db_out       <= db_next;
      change_pulse <= commit;
      any_change   <= |commit;
    end
  end

endmodule

// File: tb/tb_toggle_debouncer.sv
// Randomised and directed bench for toggle_debouncer against a tick-arithmetic
// reference model (TICK_DIV=4, STABLE_TICKS=3).
module tb_toggle_debouncer;

  localparam int WIDTH        = 18;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] raw_in = '0;
  logic [WIDTH-1:0] db_out;
  logic [WIDTH-1:0] change_pulse;
  logic             any_change;

  int checks   = 0;
  int failures = 0;

  // Reference model: each bit remembers the edge at which its synchronised level
  // started disagreeing; it commits once STABLE_TICKS tick edges have elapsed since.
  logic [WIDTH-1:0] m_db    = '0;
  logic [WIDTH-1:0] m_pulse = '0;
  logic             m_any   = 1'b0;
  int               m_edge  = 0;
  int               m_div [WIDTH];
  logic [WIDTH-1:0] m_hist [$];

  toggle_debouncer #(
    .WIDTH(WIDTH),
    .TICK_DIV(TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_in(raw_in),
    .db_out(db_out),
    .change_pulse(change_pulse),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Tick edges are those with edge index n where n mod TICK_DIV == TICK_DIV-1.
  function automatic int ticks_between(input int first, input int last);
    return (last + 1) / TICK_DIV - first / TICK_DIV;
  endfunction

  task automatic modelStep(input logic [WIDTH-1:0] sampled);
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] commit;
    if (reset) begin
      m_db    = '0;
      m_pulse = '0;
      m_any   = 1'b0;
      m_edge  = 0;
      m_hist.delete();
      foreach (m_div[i]) m_div[i] = -1;
      return;
    end
    s2     = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : '0;
    commit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2[i] == m_db[i]) begin
        m_div[i] = -1;
      end else begin
        if (m_div[i] < 0) m_div[i] = m_edge;
        if (ticks_between(m_div[i], m_edge) >= STABLE_TICKS) begin
          commit[i] = 1'b1;
          m_div[i]  = -1;
        end
      end
    end
    m_db    = m_db ^ commit;
    m_pulse = commit;
    m_any   = |commit;
    m_hist.push_back(sampled);
    if (m_hist.size() > 2) void'(m_hist.pop_front());
    m_edge++;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] value);
    raw_in = value;
    @(posedge clk);
    modelStep(value);
    #1;
    checkOutput("db_out", 64'(db_out), 64'(m_db));
    checkOutput("change_pulse", 64'(change_pulse), 64'(m_pulse));
    checkOutput("any_change", 64'(any_change), 64'(m_any));
  endtask

  initial begin
    int lat;
    int pulses;
    int anys;
    int others;
    int partial;
    logic [WIDTH-1:0] value;

    foreach (m_div[i]) m_div[i] = -1;

    reset = 1'b1;
    repeat (3) applyStimulus('0);
    checkOutput("reset_db", 64'(db_out), 64'd0);
    checkOutput("reset_pulse", 64'(change_pulse), 64'd0);
    reset = 1'b0;

    // Clean edge on bit 0
    lat = 0; pulses = 0; anys = 0; others = 0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(18'h00001);
      if (db_out[0] && lat == 0) lat = k;
      if (change_pulse[0]) pulses++;
      if (any_change) anys++;
      if (db_out[WIDTH-1:1] != '0 || change_pulse[WIDTH-1:1] != '0) others++;
    end
    checkOutput("clean_latency_window", 64'(lat >= 11 && lat <= 14), 64'd1);
    checkOutput("clean_latency", 64'(lat), 64'd12);
    checkOutput("clean_pulse_count", 64'(pulses), 64'd1);
    checkOutput("clean_any_count", 64'(anys), 64'd1);
    checkOutput("clean_other_bits", 64'(others), 64'd0);
    repeat (20) applyStimulus('0);

    // Bounce on bit 5, then settle high
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(((c / 3) % 2 == 0) ? 18'h00020 : 18'h00000);
      if (change_pulse[5]) pulses++;
    end
    checkOutput("bounce_quiet", 64'(pulses), 64'd0);
    pulses = 0;
    repeat (20) begin
      applyStimulus(18'h00020);
      if (change_pulse[5]) pulses++;
    end
    checkOutput("settle_pulses", 64'(pulses), 64'd1);
    checkOutput("settle_db", 64'(db_out[5]), 64'd1);
    repeat (20) applyStimulus('0);

    // Glitch rejection on bit 17
    pulses = 0;
    repeat (7) begin
      applyStimulus(18'h20000);
      if (change_pulse[17] || db_out[17]) pulses++;
    end
    repeat (20) begin
      applyStimulus('0);
      if (change_pulse[17] || db_out[17]) pulses++;
    end
    checkOutput("glitch_rejected", 64'(pulses), 64'd0);

    // Simultaneous rise and fall of all bits
    for (int dir = 0; dir < 2; dir++) begin
      pulses = 0; anys = 0; partial = 0;
      repeat (20) begin
        applyStimulus(dir == 0 ? ALL_ONES : '0);
        if (change_pulse == ALL_ONES) pulses++;
        else if (change_pulse != '0) partial++;
        if (any_change) anys++;
      end
      checkOutput("simul_full_pulse", 64'(pulses), 64'd1);
      checkOutput("simul_partial", 64'(partial), 64'd0);
      checkOutput("simul_any", 64'(anys), 64'd1);
      checkOutput("simul_db", 64'(db_out), dir == 0 ? 64'(ALL_ONES) : 64'd0);
    end

    // Reset mid-qualification on bit 3, with bits 0 and 8 already committed
    repeat (20) applyStimulus(18'h00101);
    repeat (8) applyStimulus(18'h00109);
    checkOutput("pre_reset_db", 64'(db_out), 64'h00101);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_db", 64'(db_out), 64'd0);
    checkOutput("async_reset_any", 64'(any_change), 64'd0);
    repeat (2) applyStimulus(18'h00109);
    reset = 1'b0;
    lat = 0; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(18'h00109);
      if (db_out[3] && lat == 0) lat = k;
      if (k == 1 && change_pulse != '0) pulses++;
    end
    checkOutput("requalify_latency", 64'(lat), 64'd12);
    checkOutput("post_reset_no_pulse", 64'(pulses), 64'd0);

    // Randomised bursts of varying hold length
    value = 18'h00109;
    for (int b = 0; b < 40; b++) begin
      value = value ^ (WIDTH'($urandom) & WIDTH'($urandom));
      repeat ($urandom_range(1, 16)) applyStimulus(value);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
